reg_file_8x8: RTL and testbench



---
 rtl/reg_file_8x8_pkg.sv | 18 +
 rtl/reg_file_8x8.sv | 69 ++++++
 tb/tb_reg_file_8x8.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_8x8_pkg.sv
// Shared sizing constants and ISA register indices for the 8x8 register file.
package reg_file_8x8_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

    // Register indices as named by the ISA; r0 is an ordinary register.
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R0 = 3'd0;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R1 = 3'd1;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R2 = 3'd2;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R3 = 3'd3;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R4 = 3'd4;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R5 = 3'd5;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R6 = 3'd6;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_R7 = 3'd7;

endpackage

// File: rtl/reg_file_8x8.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, write stall on memory busy, and a written-since-reset mask.
module reg_file_8x8
    import reg_file_8x8_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYPASS     = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WRITE,
    input  logic                     BUSYWAIT,
    input  logic [DATA_WIDTH-1:0]    IN,
    input  logic [ADDR_WIDTH-1:0]    INADDRESS,
    input  logic [ADDR_WIDTH-1:0]    OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0]    OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0]    REGOUT1,
    output logic [DATA_WIDTH-1:0]    REGOUT2,
    output logic [2**ADDR_WIDTH-1:0] VALID
);

    localparam int N_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [N_REGS];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    // RESET is folded in so the bypass path never forwards while in reset.
    assign wr_en = WRITE & ~BUSYWAIT & RESET;

    // Storage and valid mask; reset clears everything asynchronously.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
            VALID <= '0;
        end else if (wr_en) begin
            regs[INADDRESS]  <= IN;
            VALID[INADDRESS] <= 1'b1;
        end
    end

    assign stored1 = regs[OUT1ADDRESS];
    assign stored2 = regs[OUT2ADDRESS];

    if (BYPASS != 0) begin : g_bypass
        // Forward the write data to any read port addressing the write target.
        always_comb begin
            REGOUT1 = stored1;
            REGOUT2 = stored2;
            if (wr_en && (OUT1ADDRESS == INADDRESS)) begin
                REGOUT1 = IN;
            end
            if (wr_en && (OUT2ADDRESS == INADDRESS)) begin
                REGOUT2 = IN;
            end
        end
    end else begin : g_no_bypass
        // Reads always return the stored value; a new write shows after the edge.
        always_comb begin
            REGOUT1 = stored1;
            REGOUT2 = stored2;
        end
    end

endmodule

// File: tb/tb_reg_file_8x8.sv
// Bench for reg_file_8x8: a plain instance and a bypass instance share stimulus.
module tb_reg_file_8x8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITE;
    logic       BUSYWAIT;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] REGOUT1, REGOUT2, VALID;
    logic [7:0] b_regout1, b_regout2, b_valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       wr;
        logic       busy;
        logic [7:0] din;
        logic [2:0] wa;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] ev;
    } vec_t;

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] ev;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    always #5 CLK = ~CLK;

    reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0)) dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .IN(IN),
        .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .VALID(VALID)
    );

    reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1)) dut_byp (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .IN(IN),
        .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .REGOUT1(b_regout1), .REGOUT2(b_regout2), .VALID(b_valid)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge CLK);
        WRITE       = v.wr;
        BUSYWAIT    = v.busy;
        IN          = v.din;
        INADDRESS   = v.wa;
        OUT1ADDRESS = v.ra1;
        OUT2ADDRESS = v.ra2;
        sb_q.push_back('{v.e1, v.e2, v.ev});
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        check({tag, " regout1"},     REGOUT1,   e.e1);
        check({tag, " regout2"},     REGOUT2,   e.e2);
        check({tag, " valid"},       VALID,     e.ev);
        check({tag, " byp regout1"}, b_regout1, e.e1);
        check({tag, " byp regout2"}, b_regout2, e.e2);
        check({tag, " byp valid"},   b_valid,   e.ev);
    endtask

    // Control must never present an unknown write enable outside reset.
    always @(posedge CLK) begin
        if (RESET === 1'b1 && $isunknown(WRITE)) begin
            n_err++;
            $display("FAIL write_unknown: got %b, expected 0 or 1", WRITE);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  v;
        logic [7:0] vmask;
        vecs[0] = '{1'b1, 1'b0, 8'hA5, 3'd5, 3'd5, 3'd2, 8'hA5, 8'h00, 8'h20};
        vecs[1] = '{1'b1, 1'b0, 8'h3C, 3'd2, 3'd5, 3'd2, 8'hA5, 8'h3C, 8'h24};
        vecs[2] = '{1'b1, 1'b1, 8'h7F, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 8'h24};
        vecs[3] = '{1'b1, 1'b1, 8'h7F, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 8'h24};
        vecs[4] = '{1'b1, 1'b1, 8'h7F, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 8'h24};
        vecs[5] = '{1'b1, 1'b0, 8'h7F, 3'd1, 3'd1, 3'd1, 8'h7F, 8'h7F, 8'h26};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 3'd7, 3'd7, 3'd7, 8'hFF, 8'hFF, 8'hA6};
        vecs[7] = '{1'b0, 1'b0, 8'hEE, 3'd7, 3'd7, 3'd5, 8'hFF, 8'hA5, 8'hA6};
        vecs[8] = '{1'b0, 1'b1, 8'h11, 3'd3, 3'd0, 3'd3, 8'h00, 8'h00, 8'hA6};

        RESET = 1'b0; WRITE = 1'b0; BUSYWAIT = 1'b0; IN = 8'h00;
        INADDRESS = 3'd0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        repeat (2) @(negedge CLK);
        check("reset regout1", REGOUT1, 8'h00);
        check("reset valid",   VALID,   8'h00);
        RESET = 1'b1;

        // Asynchronous reset between edges clears r3 and VALID at once.
        apply('{1'b1, 1'b0, 8'h55, 3'd3, 3'd3, 3'd3, 8'h55, 8'h55, 8'h08}, "pre_reset");
        #2;
        RESET = 1'b0;
        #1;
        check("async reset regout1", REGOUT1,   8'h00);
        check("async reset valid",   VALID,     8'h00);
        check("async reset byp",     b_regout1, 8'h00);
        @(negedge CLK);
        WRITE = 1'b0;
        RESET = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Sweep: each register gets a distinct one-hot value.
        vmask = 8'hA6;
        for (int i = 0; i < 8; i++) begin
            vmask = vmask | (8'h01 << i);
            v = '{1'b1, 1'b0, 8'h01 << i, 3'(i), 3'(i), 3'(i), 8'h01 << i, 8'h01 << i, vmask};
            apply(v, $sformatf("sweep_wr%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, 1'b0, 8'h00, 3'd0, 3'(i), 3'(7 - i), 8'h01 << i, 8'h01 << (7 - i), 8'hFF};
            apply(v, $sformatf("sweep_rd%0d", i));
        end

        // Same-cycle read of the write target, with and without stall.
        apply('{1'b1, 1'b0, 8'h10, 3'd4, 3'd4, 3'd4, 8'h10, 8'h10, 8'hFF}, "r4_init");
        @(negedge CLK);
        WRITE = 1'b1; BUSYWAIT = 1'b1; IN = 8'h20; INADDRESS = 3'd4;
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd4;
        #1;
        check("stalled byp regout2", b_regout2, 8'h10);
        BUSYWAIT = 1'b0;
        #1;
        check("same cycle regout2",     REGOUT2,   8'h10);
        check("same cycle byp regout2", b_regout2, 8'h20);
        check("same cycle byp regout1", b_regout1, 8'h01);
        @(posedge CLK);
        #1;
        check("after edge regout2",     REGOUT2,   8'h20);
        check("after edge byp regout2", b_regout2, 8'h20);

        // Reset coincident with a write edge: reset wins, and holds across edges.
        @(negedge CLK);
        WRITE = 1'b1; BUSYWAIT = 1'b0; IN = 8'h99; INADDRESS = 3'd6; OUT1ADDRESS = 3'd6;
        @(posedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_wr regout1", REGOUT1, 8'h00);
        check("rst_wr valid",   VALID,   8'h00);
        @(posedge CLK);
        #1;
        check("rst_hold regout1", REGOUT1,   8'h00);
        check("rst_hold byp",     b_regout1, 8'h00);
        @(negedge CLK);
        WRITE = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst regout1", REGOUT1, 8'h00);
        check("post_rst valid",   VALID,   8'h00);
        @(negedge CLK);
        WRITE = 1'b1;
        @(posedge CLK);
        #1;
        check("rewrite regout1", REGOUT1, 8'h99);
        check("rewrite valid",   VALID,   8'h40);
        check("rewrite byp",     b_valid, 8'h40);

        @(negedge CLK);
        WRITE = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
